// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle restoring divider (DIV/DIVU), quotient to lo, remainder to hi
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dmag;
    logic             neg_q, neg_r;

    logic             accept;
    logic             last_iter;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial_rem;
    logic             trial_ok;

    assign accept    = start && (state == IDLE || state == DONE);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // Magnitudes are unsigned, so the most negative value maps cleanly onto 2^(WIDTH-1).
    assign a_neg = is_signed & dividend[WIDTH-1];
    assign b_neg = is_signed & divisor[WIDTH-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;

    // shifted < 2*dmag always holds, so the low WIDTH bits of the difference are exact when it fits.
    assign shifted   = {rem, quo[WIDTH-1]};
    assign trial_ok  = (shifted >= {1'b0, dmag});
    assign trial_rem = shifted[WIDTH-1:0] - dmag;

    assign busy = (state == RUN) || (state == FIX);
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (divisor == '0) ? DONE : RUN;
            RUN:  if (last_iter) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: begin
                if (accept) state_nxt = (divisor == '0) ? DONE : RUN;
                else        state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dmag     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            lo       <= '0;
            hi       <= '0;
        end else if (accept) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= a_mag;
            dmag     <= b_mag;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (divisor == '0);
            // Divide by zero skips the iterations and publishes its fixed result here.
            if (divisor == '0) begin
                lo <= '1;
                hi <= dividend;
            end
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            rem <= trial_ok ? trial_rem : shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], trial_ok};
        end else if (state == FIX) begin
            lo <= neg_q ? -quo : quo;
            hi <= neg_r ? -rem : rem;
        end
    end

endmodule
